bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/cpu_bus_pkg.sv | 12 +
 rtl/bus_arbiter_if.sv | 20 ++
 rtl/bus_watchdog.sv | 19 +
 rtl/bus_arbiter.sv | 91 +++++++++
 tb/tb_bus_arbiter.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared encodings for the instruction/data bus arbiter
package cpu_bus_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_IF_ACC = 2'd1, ST_MEM_ACC = 2'd2} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_MEM = 1'b1} owner_t;
  localparam logic [1:0] BUS_ERR_NONE = 2'b00;
  localparam logic [1:0] BUS_ERR_IF = 2'b01;
  localparam logic [1:0] BUS_ERR_MEM = 2'b10;
  localparam int unsigned DEFAULT_TIMEOUT = 255;
  function automatic logic [1:0] err_code(owner_t own);
    return own == OWN_MEM ? BUS_ERR_MEM : BUS_ERR_IF;
  endfunction
endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: fetch port, data port and shared memory bus around the arbiter
interface bus_arbiter_if;
  logic        if_req, if_abort, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        mem_req, mem_we, mem_stall;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_sel;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_sel;
  logic [1:0]  bus_err;
  modport slave (
    input  if_req, if_addr, if_abort, mem_req, mem_we, mem_addr, mem_wdata, mem_sel, bus_ack, bus_rdata,
    output if_rdata, if_stall, mem_rdata, mem_stall, bus_req, bus_we, bus_addr, bus_wdata, bus_sel, bus_err
  );
  modport master (
    output if_req, if_addr, if_abort, mem_req, mem_we, mem_addr, mem_wdata, mem_sel, bus_ack, bus_rdata,
    input  if_rdata, if_stall, mem_rdata, mem_stall, bus_req, bus_we, bus_addr, bus_wdata, bus_sel, bus_err
  );
endinterface

// File: rtl/bus_watchdog.sv
// bus_watchdog: counts bus cycles of the current access; flags its last live cycle and its expiry
module bus_watchdog
  import cpu_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic near,
  output logic tmo
);
  logic [7:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? 8'd0 : en ? cnt_q + 8'd1 : cnt_q;
  assign near = cnt_q == 8'(TIMEOUT - 1);
  assign tmo = cnt_q == 8'(TIMEOUT);
  always_ff @(posedge clk) cnt_q <= !reset ? 8'd0 : cnt_d;
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: grants one shared memory bus to fetch or data requests (data first),
// with a watchdog abort per access and dropping of fetches made stale by a PC redirect
module bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input logic clk,
  input logic reset,
  bus_arbiter_if.slave bif
);
  state_t      state_q, state_d;
  logic        discard_q, discard_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic [1:0]  bus_err_q, bus_err_d;
  logic        idle, in_if, in_mem, acc, near, tmo, ack, done, drop, expire, want_if, want_mem;
  bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk), .reset(reset), .clr(want_if || want_mem || done), .en(acc), .near(near), .tmo(tmo)
  );
  assign idle = state_q == ST_IDLE;
  // reset gating makes the stalls track the requests from the very first reset cycle
  assign in_if = reset && state_q == ST_IF_ACC;
  assign in_mem = reset && state_q == ST_MEM_ACC;
  assign acc = in_if || in_mem;
  assign ack = acc && bif.bus_ack && !tmo;
  assign done = ack || (acc && tmo);
  assign drop = discard_q || bif.if_abort;
  assign expire = acc && near && !bif.bus_ack;
  assign want_mem = bif.mem_req && (done ? in_if : idle);
  assign want_if = bif.if_req && (done ? in_mem : idle && !bif.mem_req);
  always_comb begin
    state_d = done ? ST_IDLE : state_q;
    discard_d = !done && (discard_q || (in_if && bif.if_abort));
    bus_req_d = bus_req_q && !done && !expire;
    bus_err_d = expire ? err_code(in_mem ? OWN_MEM : OWN_IF) : BUS_ERR_NONE;
    bus_we_d = bus_we_q;
    bus_addr_d = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_sel_d = bus_sel_q;
    if (want_mem) begin
      state_d = ST_MEM_ACC;
      bus_req_d = 1'b1;
      bus_we_d = bif.mem_we;
      bus_addr_d = bif.mem_addr;
      bus_wdata_d = bif.mem_wdata;
      bus_sel_d = bif.mem_sel;
    end else if (want_if) begin
      state_d = ST_IF_ACC;
      bus_req_d = 1'b1;
      bus_we_d = 1'b0;
      bus_addr_d = bif.if_addr;
      bus_wdata_d = 32'h0;
      bus_sel_d = 4'hF;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      discard_q <= 1'b0;
      bus_req_q <= 1'b0;
      bus_we_q <= 1'b0;
      bus_addr_q <= 32'h0;
      bus_wdata_q <= 32'h0;
      bus_sel_q <= 4'h0;
      bus_err_q <= BUS_ERR_NONE;
    end else begin
      state_q <= state_d;
      discard_q <= discard_d;
      bus_req_q <= bus_req_d;
      bus_we_q <= bus_we_d;
      bus_addr_q <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_sel_q <= bus_sel_d;
      bus_err_q <= bus_err_d;
    end
  end
  assign bif.bus_req = bus_req_q && reset;
  assign bif.bus_we = bus_we_q;
  assign bif.bus_addr = bus_addr_q;
  assign bif.bus_wdata = bus_wdata_q;
  assign bif.bus_sel = bus_sel_q;
  assign bif.bus_err = reset ? bus_err_q : BUS_ERR_NONE;
  assign bif.if_stall = bif.if_req && !(in_if && done && !drop);
  assign bif.if_rdata = in_if && ack && !drop ? bif.bus_rdata : 32'h0;
  assign bif.mem_stall = bif.mem_req && !(in_mem && done);
  assign bif.mem_rdata = in_mem && ack && !bus_we_q ? bif.bus_rdata : 32'h0;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios then random traffic, checked against a transaction-level model
module tb_bus_arbiter;
  import cpu_bus_pkg::*;
  localparam int unsigned TO = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  bus_arbiter_if bif();
  bus_arbiter #(.TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bif(bif));
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_pass = 0;
  // model: owner 0 none / 1 fetch / 2 data; age = bus cycles since grant, counting from 1
  int m_own = 0;
  int unsigned m_age = 0;
  bit m_stale = 1'b0;
  logic m_we = 1'b0;
  logic [31:0] m_addr = 32'h0, m_wdata = 32'h0;
  logic [3:0] m_sel = 4'h0;
  bit e_done, e_if_stall, e_mem_stall;
  bit if_cmpl = 1'b0, mem_cmpl = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic look();
    int own;
    bit tmo, ack, drop, live;
    #1;
    own = reset ? m_own : 0;
    tmo = own != 0 && m_age == TO + 1;
    ack = own != 0 && bif.bus_ack && !tmo;
    e_done = ack || tmo;
    drop = m_stale || bif.if_abort;
    live = own != 0 && m_age <= TO;
    e_if_stall = bif.if_req && !(own == 1 && e_done && !drop);
    e_mem_stall = bif.mem_req && !(own == 2 && e_done);
    chk("if_stall", 32'(bif.if_stall), 32'(e_if_stall));
    chk("mem_stall", 32'(bif.mem_stall), 32'(e_mem_stall));
    chk("if_rdata", bif.if_rdata, (own == 1 && ack && !drop) ? bif.bus_rdata : 32'h0);
    chk("mem_rdata", bif.mem_rdata, (own == 2 && ack && !m_we) ? bif.bus_rdata : 32'h0);
    chk("bus_req", 32'(bif.bus_req), 32'(live));
    chk("bus_err", 32'(bif.bus_err), 32'(!tmo ? 2'b00 : own == 1 ? 2'b01 : 2'b10));
    if (live) begin
      chk("bus_addr", bif.bus_addr, m_addr);
      chk("bus_wdata", bif.bus_wdata, m_wdata);
      chk("bus_sel", 32'(bif.bus_sel), 32'(m_sel));
      chk("bus_we", 32'(bif.bus_we), 32'(m_we));
    end
  endtask

  task automatic tick();
    int nxt;
    @(posedge clk);
    if (!reset) begin
      m_own = 0; m_age = 0; m_stale = 1'b0;
      m_we = 1'b0; m_addr = 32'h0; m_wdata = 32'h0; m_sel = 4'h0;
    end else if (m_own != 0 && !e_done) begin
      m_age++;
      if (m_own == 1 && bif.if_abort) m_stale = 1'b1;
    end else begin
      nxt = m_own == 0 ? (bif.mem_req ? 2 : bif.if_req ? 1 : 0)
          : m_own == 2 ? (bif.if_req ? 1 : 0) : (bif.mem_req ? 2 : 0);
      m_own = nxt; m_age = 1; m_stale = 1'b0;
      if (nxt == 2) begin
        m_we = bif.mem_we; m_addr = bif.mem_addr; m_wdata = bif.mem_wdata; m_sel = bif.mem_sel;
      end else if (nxt == 1) begin
        m_we = 1'b0; m_addr = bif.if_addr; m_wdata = 32'h0; m_sel = 4'hF;
      end
    end
    #1;
  endtask

  initial begin
    bif.if_req = 1'b0; bif.if_addr = 32'h0; bif.if_abort = 1'b0;
    bif.mem_req = 1'b0; bif.mem_we = 1'b0; bif.mem_addr = 32'h0; bif.mem_wdata = 32'h0; bif.mem_sel = 4'h0;
    bif.bus_ack = 1'b0; bif.bus_rdata = 32'h0;
    tick(); tick();
    bif.if_req = 1'b1; bif.mem_req = 1'b1;
    look();
    chk("rst_if_stall", 32'(bif.if_stall), 32'd1);
    chk("rst_mem_stall", 32'(bif.mem_stall), 32'd1);
    chk("rst_bus_req", 32'(bif.bus_req), 32'd0);
    chk("rst_bus_addr", bif.bus_addr, 32'h0);
    chk("rst_bus_err", 32'(bif.bus_err), 32'd0);
    tick();
    bif.if_req = 1'b0; bif.mem_req = 1'b0; reset = 1'b1;
    look(); tick();
    // single fetch, ack on the second bus cycle
    bif.if_req = 1'b1; bif.if_addr = 32'h0000_0400;
    look(); chk("f_stall0", 32'(bif.if_stall), 32'd1); tick();
    look(); chk("f_stall1", 32'(bif.if_stall), 32'd1); chk("f_addr", bif.bus_addr, 32'h400); tick();
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h2402_0005;
    look(); chk("f_stall2", 32'(bif.if_stall), 32'd0); chk("f_rdata", bif.if_rdata, 32'h2402_0005); tick();
    bif.if_req = 1'b0; bif.bus_ack = 1'b0;
    look(); chk("f_req_off", 32'(bif.bus_req), 32'd0); tick();
    // simultaneous requests: data first, fetch back-to-back
    bif.if_req = 1'b1; bif.if_addr = 32'h404;
    bif.mem_req = 1'b1; bif.mem_addr = 32'h1000; bif.mem_we = 1'b0; bif.mem_sel = 4'hF;
    look(); tick();
    look(); chk("pri_addr", bif.bus_addr, 32'h1000); tick();
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h1122_3344;
    look();
    chk("pri_mem_stall", 32'(bif.mem_stall), 32'd0);
    chk("pri_if_stall", 32'(bif.if_stall), 32'd1);
    chk("pri_mem_rdata", bif.mem_rdata, 32'h1122_3344);
    tick();
    bif.mem_req = 1'b0; bif.bus_ack = 1'b0;
    look(); chk("b2b_addr", bif.bus_addr, 32'h404); chk("b2b_req", 32'(bif.bus_req), 32'd1); tick();
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h0800_0000;
    look(); chk("b2b_if_stall", 32'(bif.if_stall), 32'd0); tick();
    bif.if_req = 1'b0; bif.bus_ack = 1'b0;
    // store holds its bus fields and returns no data
    bif.mem_req = 1'b1; bif.mem_we = 1'b1; bif.mem_sel = 4'b0011;
    bif.mem_wdata = 32'hDEAD_BEEF; bif.mem_addr = 32'h2000;
    look(); tick();
    for (int i = 0; i < 2; i++) begin
      look();
      chk("st_wdata", bif.bus_wdata, 32'hDEAD_BEEF);
      chk("st_sel", 32'(bif.bus_sel), 32'h3);
      chk("st_we", 32'(bif.bus_we), 32'd1);
      tick();
    end
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'hFFFF_FFFF;
    look(); chk("st_rdata", bif.mem_rdata, 32'h0); chk("st_stall", 32'(bif.mem_stall), 32'd0); tick();
    bif.mem_req = 1'b0; bif.mem_we = 1'b0; bif.bus_ack = 1'b0;
    // PC redirect during a fetch: stale word dropped, new fetch follows
    bif.if_req = 1'b1; bif.if_addr = 32'h500;
    look(); tick();
    bif.if_abort = 1'b1; bif.if_addr = 32'h600;
    look(); tick();
    bif.if_abort = 1'b0; bif.bus_ack = 1'b1; bif.bus_rdata = 32'h1234_5678;
    look(); chk("ab_stall", 32'(bif.if_stall), 32'd1); chk("ab_rdata", bif.if_rdata, 32'h0); tick();
    bif.bus_ack = 1'b0;
    look(); tick();
    look(); chk("ab_new_addr", bif.bus_addr, 32'h600); tick();
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h8765_4321;
    look(); chk("ab_new_stall", 32'(bif.if_stall), 32'd0); chk("ab_new_rdata", bif.if_rdata, 32'h8765_4321); tick();
    bif.if_req = 1'b0; bif.bus_ack = 1'b0;
    // watchdog expiry on a load
    bif.mem_req = 1'b1; bif.mem_addr = 32'h3000;
    look(); tick();
    for (int i = 0; i < 4; i++) begin
      look(); chk("to_req_held", 32'(bif.bus_req), 32'd1); tick();
    end
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h5555_5555;
    look();
    chk("to_req", 32'(bif.bus_req), 32'd0);
    chk("to_err", 32'(bif.bus_err), 32'h2);
    chk("to_stall", 32'(bif.mem_stall), 32'd0);
    chk("to_rdata", bif.mem_rdata, 32'h0);
    tick();
    bif.mem_req = 1'b0; bif.bus_ack = 1'b0;
    look(); chk("to_err_off", 32'(bif.bus_err), 32'd0); tick();
    // reset in the middle of a load, late ack afterwards
    bif.mem_req = 1'b1; bif.mem_addr = 32'h4000;
    look(); tick();
    look(); tick();
    reset = 1'b0;
    look(); chk("mr_req", 32'(bif.bus_req), 32'd0); chk("mr_stall", 32'(bif.mem_stall), 32'd1); tick();
    reset = 1'b1; bif.mem_req = 1'b0;
    look(); tick();
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h9999_9999;
    look(); chk("mr_late_req", 32'(bif.bus_req), 32'd0); chk("mr_late_rdata", bif.mem_rdata, 32'h0); tick();
    bif.bus_ack = 1'b0; bif.if_req = 1'b1; bif.if_addr = 32'h700;
    look(); tick();
    look(); chk("mr_idle_grant", bif.bus_addr, 32'h700); tick();
    bif.bus_ack = 1'b1;
    look(); chk("mr_fetch_done", 32'(bif.if_stall), 32'd0); tick();
    bif.if_req = 1'b0; bif.bus_ack = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      reset = $urandom_range(0, 79) != 0;
      if (!bif.if_req || if_cmpl) begin
        bif.if_req = 1'($urandom_range(0, 1));
        bif.if_addr = $urandom & 32'hFFFF_FFFC;
      end
      bif.if_abort = $urandom_range(0, 9) == 0;
      if (bif.if_abort) bif.if_addr = $urandom & 32'hFFFF_FFFC;
      if (!bif.mem_req || mem_cmpl) begin
        bif.mem_req = 1'($urandom_range(0, 1));
        bif.mem_we = 1'($urandom_range(0, 1));
        bif.mem_addr = $urandom;
        bif.mem_wdata = $urandom;
        bif.mem_sel = 4'($urandom);
      end
      bif.bus_ack = $urandom_range(0, 2) == 0;
      bif.bus_rdata = $urandom;
      look();
      if_cmpl = bif.if_req && !e_if_stall;
      mem_cmpl = bif.mem_req && !e_mem_stall;
      tick();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
